// File: rtl/nonblocking_reader_if.sv
// Handshake bundle for nonblocking_reader: parallel quad in, serial word stream out.
// The producer/consumer side takes the master modport; the reader takes slave.
interface nonblocking_reader_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_index;
    logic             out_last;
    logic [CNT_W-1:0] quad_count;

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, quad_count
    );

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, quad_count
    );
endinterface

// File: rtl/nonblocking_reader.sv
// Captures {a,b,c,d} quads into a two-slot ping-pong buffer and emits them
// serially a..d on a valid/ready stream, counting completed quads.
module nonblocking_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                 clock,
    input logic                 reset,
    nonblocking_reader_if.slave bus
);
    logic [1:0][3:0][WIDTH-1:0] slot;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 occ;
    logic [1:0]                 idx;
    logic [CNT_W-1:0]           qcnt;

    logic cap, xfer, done;

    // Handshake outputs depend only on registered state, never on out_ready/in_valid.
    assign bus.in_ready   = (occ != 2'd2);
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.out_data   = slot[rd_ptr][idx];
    assign bus.out_index  = idx;
    assign bus.out_last   = bus.out_valid && (idx == 2'd3);
    assign bus.quad_count = qcnt;

    assign cap  = bus.in_valid && bus.in_ready;
    assign xfer = bus.out_valid && bus.out_ready;
    assign done = xfer && (idx == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            idx    <= 2'd0;
            qcnt   <= '0;
        end else begin
            if (cap) begin
                slot[wr_ptr] <= {bus.d, bus.c, bus.b, bus.a};
                wr_ptr       <= ~wr_ptr;
            end
            // idx wraps 3->0 on its own, so the last word needs no special case here
            if (xfer)
                idx <= idx + 2'd1;
            if (done) begin
                rd_ptr <= ~rd_ptr;
                qcnt   <= qcnt + 1'b1;
            end
            case ({cap, done})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule
